// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - mode and state encodings for the sequence engine
package seq_pkg;

  typedef enum logic [1:0] {
    FIB  = 2'd0,
    TRI  = 2'd1,
    SQR  = 2'd2,
    POW2 = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_tick.sv
// rtl/seq_tick.sv - prescaler producing one tick every (period+1) << SHIFT cycles
module seq_tick #(
  parameter int PROG_W = 3,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [PROG_W-1:0] period,
  output logic              tick
);

  localparam int CW = PROG_W + SHIFT;
  // (period+1) << SHIFT minus one is period << SHIFT with all low bits set
  localparam logic [CW-1:0] LOW_ONES = CW'((64'd1 << SHIFT) - 64'd1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;

  assign limit = (CW'(period) << SHIFT) | LOW_ONES;
  assign tick  = en && (cnt == limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_engine.sv
// rtl/seq_engine.sv - four-mode integer sequence generator with overflow stop
module seq_engine
  import seq_pkg::*;
#(
  parameter int W      = 16,
  parameter int PROG_W = 3,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              stop,
  input  logic              update,
  input  logic [PROG_W-1:0] prog,
  output logic [W-1:0]      value,
  output logic [W-1:0]      index,
  output logic              step,
  output logic              busy,
  output logic              ovf,
  output logic [1:0]        state
);

  state_t            st;
  mode_t             mode_r;
  logic [PROG_W-1:0] period;
  logic [W:0]        fib_b;
  logic [W:0]        fib_sum;
  logic [W:0]        nxt;
  logic              tick;
  logic              go;

  assign state = st;
  assign go    = start && !stop;

  seq_tick #(
    .PROG_W (PROG_W),
    .SHIFT  (SHIFT)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (st == RUN),
    .clr    (start || update || stop),
    .period (period),
    .tick   (tick)
  );

  // fib_b holds the Fibonacci term after value; it is one bit wider so the
  // pair sum never loses its carry before the overflow test sees it
  assign fib_sum = {1'b0, value} + fib_b;

  always_comb begin
    nxt = '0;
    case (mode_r)
      FIB:  nxt = fib_b;
      TRI:  nxt = {1'b0, value} + {1'b0, index} + (W+1)'(1);
      SQR:  nxt = {1'b0, value} + {index, 1'b1};
      POW2: nxt = {value, 1'b0};
      default: nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= IDLE;
      mode_r <= FIB;
      period <= '0;
      value  <= '0;
      index  <= '0;
      fib_b  <= '0;
      step   <= 1'b0;
      busy   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (update) period <= prog;
      if (go) begin
        st     <= RUN;
        busy   <= 1'b1;
        ovf    <= 1'b0;
        step   <= 1'b1;
        mode_r <= mode_t'(mode);
        index  <= '0;
        value  <= (mode_t'(mode) == POW2) ? W'(1) : '0;
        fib_b  <= (W+1)'(1);
      end else if (st == RUN) begin
        if (stop) begin
          st   <= IDLE;
          busy <= 1'b0;
        end else if (tick) begin
          if (nxt[W]) begin
            st   <= DONE;
            busy <= 1'b0;
            ovf  <= 1'b1;
          end else begin
            value <= nxt[W-1:0];
            fib_b <= fib_sum;
            index <= index + W'(1);
            step  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_engine.sv
// tb/tb_seq_engine.sv - scoreboard bench for seq_engine at W=8, SHIFT=0
module tb_seq_engine;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         update = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [2:0]   prog = 3'd0;
  logic [W-1:0] value;
  logic [W-1:0] index;
  logic         step;
  logic         busy;
  logic         ovf;
  logic [1:0]   state;

  typedef struct {
    int v;
    int i;
  } term_t;

  term_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_cyc = 0;
  int    exp_gap = 1;
  bit    gap_chk = 1'b1;
  bit    first = 1'b0;

  seq_engine #(
    .W      (W),
    .PROG_W (3),
    .SHIFT  (0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .stop   (stop),
    .update (update),
    .prog   (prog),
    .value  (value),
    .index  (index),
    .step   (step),
    .busy   (busy),
    .ovf    (ovf),
    .state  (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference sequence up to the last term that fits in W bits
  function automatic void fill(input int m);
    int v, fb, i, n, nxt;
    q.delete();
    v  = (m == 3) ? 1 : 0;
    fb = 1;
    i  = 0;
    forever begin
      q.push_back('{v: v, i: i});
      n = i + 1;
      case (m)
        0:       nxt = fb;
        1:       nxt = v + n;
        2:       nxt = v + 2 * n - 1;
        default: nxt = 2 * v;
      endcase
      if (nxt > 255) break;
      if (m == 0) fb = v + fb;
      v = nxt;
      i = n;
    end
  endfunction

  always @(negedge clk) begin
    if (rst && step) begin
      if (q.size() == 0) begin
        check("unexpected_step", {31'b0, step}, 32'd0);
      end else begin
        term_t e;
        e = q.pop_front();
        check("term_value", value, e.v);
        check("term_index", index, e.i);
        if (gap_chk) check("term_gap", cyc - last_cyc, first ? 0 : exp_gap);
        last_cyc = cyc;
        first    = 1'b0;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prog(input int p);
    prog   = p[2:0];
    update = 1'b1;
    cycle();
    update  = 1'b0;
    exp_gap = p + 1;
  endtask

  task automatic do_start(input int m);
    mode  = m[1:0];
    start = 1'b1;
    cycle();
    start = 1'b0;
    fill(m);
    first    = 1'b1;
    last_cyc = cyc;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    q.delete();
  endtask

  task automatic wait_state(input string tag, input int s, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (state == s[1:0]) break;
      cycle();
    end
    check(tag, state, s);
  endtask

  task automatic check_done(input string tag, input int v, input int i);
    wait_state({tag, "_done"}, 2, 300);
    check({tag, "_value"}, value, v);
    check({tag, "_index"}, index, i);
    check({tag, "_ovf"}, ovf, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_left"}, q.size(), 0);
  endtask

  initial begin
    repeat (3) cycle();
    check("rst_value", value, 0);
    check("rst_index", index, 0);
    check("rst_step", step, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state", state, 0);
    rst = 1'b1;
    cycle();

    set_prog(3);
    do_start(0);
    check("fib_busy", busy, 1);
    check_done("fib", 233, 13);

    set_prog(0);
    do_start(3);
    check_done("pow2", 128, 7);
    do_start(1);
    check_done("tri", 253, 22);
    do_start(2);
    check_done("sqr", 225, 15);

    // stop ten cycles after start at period 0
    do_start(0);
    repeat (9) cycle();
    do_stop();
    check("stop_state", state, 0);
    check("stop_value", value, 34);
    check("stop_index", index, 9);
    repeat (10) cycle();
    check("stop_hold_value", value, 34);
    check("stop_hold_index", index, 9);
    do_start(0);
    repeat (3) cycle();
    check("restart_value", value, 2);
    check("restart_index", index, 3);
    do_stop();

    // stop and start together (also coincides with a tick)
    do_start(1);
    repeat (2) cycle();
    mode  = 2'd2;
    start = 1'b1;
    stop  = 1'b1;
    cycle();
    start = 1'b0;
    stop  = 1'b0;
    q.delete();
    check("ss_state", state, 0);
    check("ss_value", value, 3);
    check("ss_index", index, 2);
    repeat (4) cycle();
    check("ss_hold_state", state, 0);

    // stop on the same edge as a tick
    set_prog(3);
    do_start(0);
    repeat (7) cycle();
    do_stop();
    check("st_state", state, 0);
    check("st_value", value, 1);
    check("st_index", index, 1);
    repeat (6) cycle();

    // restart in squares mode while triangular runs
    set_prog(1);
    do_start(1);
    repeat (5) cycle();
    do_start(2);
    check("rs_value", value, 0);
    check("rs_index", index, 0);
    check("rs_step", step, 1);
    check_done("rs", 225, 15);

    // period change mid-run
    gap_chk = 1'b0;
    set_prog(7);
    do_start(1);
    repeat (2) cycle();
    set_prog(5);
    begin
      int u;
      u = cyc;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (step) break;
      end
      check("upd_step_seen", step, 1);
      check("upd_gap", cyc - u, 6);
    end
    cycle();
    do_stop();
    gap_chk = 1'b1;

    // asynchronous reset mid-run loses the period
    set_prog(6);
    do_start(0);
    repeat (3) cycle();
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    check("arst_value", value, 0);
    check("arst_index", index, 0);
    check("arst_step", step, 0);
    check("arst_busy", busy, 0);
    check("arst_ovf", ovf, 0);
    check("arst_state", state, 0);
    cycle();
    rst = 1'b1;
    cycle();
    exp_gap = 1;
    do_start(3);
    check_done("arst_pow2", 128, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
